// File: rtl/csi_lane_aligner_pkg.sv
// Shared types and constants for the CSI lane deskew stage.
// Lane-count-dependent port vectors are sized by the NUM_LANE parameter of each module.
package csi_lane_aligner_pkg;

  localparam int ALIGN_DEPTH = 8;
  localparam int ALIGN_LANES = 2;

  typedef logic [ALIGN_LANES*8-1:0] lane_data_t;
  typedef logic [ALIGN_LANES-1:0]   lane_vld_t;

  typedef enum logic [1:0] {
    IDLE,
    ALIGNED,
    FLUSH
  } align_state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/csi_lane_aligner_fifo.sv
// Single-clock byte FIFO for one lane with show-ahead read data and a one-cycle clear.
// Writes to a full FIFO are dropped unless a read frees the slot in the same cycle.
module csi_lane_fifo #(
  parameter int DEPTH = 8,
  parameter int LW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          wr,
  input  logic [7:0]    wdata,
  input  logic          rd,
  output logic [7:0]    rdata,
  output logic [LW-1:0] lvl
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q;
  logic [AW-1:0] rptr_q;
  logic [LW-1:0] lvl_q;
  logic          do_wr;
  logic          do_rd;

  assign do_rd = rd && (lvl_q != '0);
  assign do_wr = wr && ((lvl_q != LW'(DEPTH)) || do_rd);

  // NOTE: the storage array has no reset; pointers and level alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (do_wr && !clr) mem_q[wptr_q] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      lvl_q  <= '0;
    end else if (clr) begin
      wptr_q <= '0;
      rptr_q <= '0;
      lvl_q  <= '0;
    end else begin
      if (do_wr) wptr_q <= wptr_q + AW'(1);
      if (do_rd) rptr_q <= rptr_q + AW'(1);
      if (do_wr && !do_rd)      lvl_q <= lvl_q + LW'(1);
      else if (!do_wr && do_rd) lvl_q <= lvl_q - LW'(1);
    end
  end

  assign rdata = mem_q[rptr_q];
  assign lvl   = lvl_q;

endmodule

// File: rtl/csi_lane_aligner.sv
// Multi-lane deskew: buffers each lane, releases one lane-aligned word per cycle once every
// lane holds data, emits a masked final partial word and flags skew beyond the FIFO depth.
module csi_lane_aligner
  import csi_lane_aligner_pkg::*;
#(
  parameter int NUM_LANE = ALIGN_LANES,
  parameter int DEPTH    = ALIGN_DEPTH,
  parameter int LW       = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_LANE*8-1:0] in_data,
  input  logic [NUM_LANE-1:0]   in_vld,
  output logic [NUM_LANE*8-1:0] out_data,
  output logic                  out_vld,
  output logic [NUM_LANE-1:0]   out_lane_vld,
  output logic                  out_last,
  output logic [LW-1:0]         skew,
  output logic                  err_skew,
  output logic [7:0]            err_cnt
);

  align_state_t          state_q;
  logic [NUM_LANE*8-1:0] out_data_q;
  logic                  out_vld_q;
  logic [NUM_LANE-1:0]   out_lane_vld_q;
  logic                  out_last_q;
  logic [LW-1:0]         skew_q;
  logic                  err_skew_q;
  logic [7:0]            err_cnt_q;

  logic [LW-1:0]         lvl   [NUM_LANE];
  logic [7:0]            rdata [NUM_LANE];
  logic [NUM_LANE-1:0]   ne;
  logic [NUM_LANE-1:0]   wr_en;
  logic [NUM_LANE-1:0]   rd_en;
  logic                  clr;
  logic                  any_full;
  logic [LW-1:0]         max_lvl;
  logic [NUM_LANE*8-1:0] word_d;
  logic [7:0]            err_cnt_d;

  assign clr       = (state_q == FLUSH);
  assign wr_en     = clr ? '0 : in_vld;
  assign rd_en     = (state_q == ALIGNED) ? ne : '0;
  assign err_cnt_d = sat_inc8(err_cnt_q);

  for (genvar g = 0; g < NUM_LANE; g++) begin : g_lane
    csi_lane_fifo #(
      .DEPTH (DEPTH),
      .LW    (LW)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .clr   (clr),
      .wr    (wr_en[g]),
      .wdata (in_data[g*8 +: 8]),
      .rd    (rd_en[g]),
      .rdata (rdata[g]),
      .lvl   (lvl[g])
    );
  end

  // Empty lanes contribute zero bytes, which is exactly the final partial word layout.
  always_comb begin
    // NOTE: every combinational result gets a default first so no path can infer a latch.
    ne       = '0;
    any_full = 1'b0;
    max_lvl  = '0;
    word_d   = '0;
    for (int i = 0; i < NUM_LANE; i++) begin
      ne[i] = (lvl[i] != '0);
      if (lvl[i] == LW'(DEPTH)) any_full = 1'b1;
      if (lvl[i] > max_lvl)     max_lvl  = lvl[i];
      if (lvl[i] != '0)         word_d[i*8 +: 8] = rdata[i];
    end
  end

  // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      out_data_q     <= '0;
      out_vld_q      <= 1'b0;
      out_lane_vld_q <= '0;
      out_last_q     <= 1'b0;
      skew_q         <= '0;
      err_skew_q     <= 1'b0;
      err_cnt_q      <= '0;
    end else begin
      out_data_q     <= '0;
      out_vld_q      <= 1'b0;
      out_lane_vld_q <= '0;
      out_last_q     <= 1'b0;
      err_skew_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          // Alignment takes priority over overflow when both happen in the same cycle.
          if (&ne) begin
            state_q <= ALIGNED;
            skew_q  <= max_lvl - LW'(1);
          end else if (any_full) begin
            state_q    <= FLUSH;
            err_skew_q <= 1'b1;
            err_cnt_q  <= err_cnt_d;
          end
        end
        ALIGNED: begin
          if (&ne) begin
            out_data_q     <= word_d;
            out_vld_q      <= 1'b1;
            out_lane_vld_q <= ne;
          end else if (|ne) begin
            out_data_q     <= word_d;
            out_vld_q      <= 1'b1;
            out_lane_vld_q <= ne;
            out_last_q     <= 1'b1;
            state_q        <= FLUSH;
          end else begin
            state_q <= FLUSH;
          end
        end
        FLUSH: begin
          if (in_vld == '0) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_data     = out_data_q;
  assign out_vld      = out_vld_q;
  assign out_lane_vld = out_lane_vld_q;
  assign out_last     = out_last_q;
  assign skew         = skew_q;
  assign err_skew     = err_skew_q;
  assign err_cnt      = err_cnt_q;

endmodule
